// File: rtl/slink_rx_arb.sv
// slink_rx_arb
// Packet-granular round-robin scheduler. It drains CH_NUM slink receive
// packet FIFOs and merges them onto one valid/ready stream toward the MM side.
// Packets are never interleaved. Framing (sop placement) is policed, and so is
// length when the optional check is built in.
//
// Optional feature: define SLINK_ARB_LEN_CHK_EN to enable the maximum packet
// length check and the DROP state. When it is undefined, only sop framing
// violations are reported.
//
// Parameters:
//   CH_NUM        number of receive channels (2..8)
//   CH_W          channel index width, CH_NUM <= 2**CH_W
//   MAX_PKT_WORDS longest legal packet in 16-bit words
//
// Ports:
//   clk_rd          single clock for the block
//   rst_rd          synchronous active-high reset
//   slink_mm_empty  per-channel FIFO empty flags
//   slink_mm_data   per-channel FIFO read data, channel i at [18i+17:18i]
//                   (bit17 sop, bit16 eop, [15:0] payload)
//   mm_slink_rdreq  per-channel read request; data is valid one cycle later
//   arb_mm_rdy      downstream accepts the presented word
//   arb_mm_dval     output word valid
//   arb_mm_data     output word, same bit map as the input words
//   arb_mm_chn      source channel of the presented word
//   arb_err         one-cycle framing/length error pulse
//   arb_state       FSM state for observation (0 IDLE, 1 XFER, 2 DROP)
//
// Handshake: a word transfers in every cycle where arb_mm_dval and arb_mm_rdy
// are both high. arb_mm_dval/arb_mm_data/arb_mm_chn stay stable while
// arb_mm_dval is high and arb_mm_rdy is low, and dval never depends on rdy.

module slink_rx_arb #(
    parameter int CH_NUM        = 4,
    parameter int CH_W          = 2,
    parameter int MAX_PKT_WORDS = 1024
) (
    input  logic                 clk_rd,
    input  logic                 rst_rd,
    input  logic [CH_NUM-1:0]    slink_mm_empty,
    input  logic [18*CH_NUM-1:0] slink_mm_data,
    output logic [CH_NUM-1:0]    mm_slink_rdreq,
    input  logic                 arb_mm_rdy,
    output logic                 arb_mm_dval,
    output logic [17:0]          arb_mm_data,
    output logic [CH_W-1:0]      arb_mm_chn,
    output logic                 arb_err,
    output logic [1:0]           arb_state
);

    localparam int CNT_W = ($clog2(MAX_PKT_WORDS + 1) > 11) ? $clog2(MAX_PKT_WORDS + 1) : 11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH_NUM - 1);

    logic [1:0]        state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [CNT_W-1:0]  word_cnt;
    logic              rdreq_d1;
    logic [1:0]        buf_cnt;
    // Two-entry output buffer, entry = {channel, word}; buf0 is the head.
    logic [CH_W+17:0]  buf0;
    logic [CH_W+17:0]  buf1;

    logic [CH_W-1:0]   pick;
    logic              pick_vld;
    int                pick_idx;
    logic [CH_W-1:0]   pick_cand;
    logic              rd_ok;
    logic [17:0]       cap_word;
    logic              cap_sop;
    logic              cap_eop;
    logic              sop_err;
    logic              len_hit;
    logic              push;
    logic              pop;
    logic [CH_W+17:0]  push_word;

    // Round-robin search starting after last_grant. Iterating from the
    // farthest candidate down lets the nearest non-empty channel win.
    always_comb begin
        pick      = '0;
        pick_vld  = 1'b0;
        pick_idx  = 0;
        pick_cand = '0;
        for (int i = CH_NUM; i >= 1; i--) begin
            pick_idx  = (int'(last_grant) + i) % CH_NUM;
            pick_cand = CH_W'(pick_idx);
            if (!slink_mm_empty[pick_cand]) begin
                pick     = pick_cand;
                pick_vld = 1'b1;
            end
        end
    end

    // A single read in flight. In XFER the read also needs buffer room for the
    // word it will bring back. DROP discards words, so it ignores buffer room.
    always_comb begin
        rd_ok = 1'b0;
        if (state == S_XFER)
            rd_ok = !rdreq_d1 && (({1'b0, buf_cnt} + {2'b00, rdreq_d1}) < 3'd2);
`ifdef SLINK_ARB_LEN_CHK_EN
        else if (state == S_DROP)
            rd_ok = !rdreq_d1;
`endif
        mm_slink_rdreq = '0;
        for (int i = 0; i < CH_NUM; i++)
            mm_slink_rdreq[i] = rd_ok && !slink_mm_empty[i] && (grant == CH_W'(i));
    end

    always_comb begin
        cap_word = '0;
        for (int i = 0; i < CH_NUM; i++)
            if (grant == CH_W'(i))
                cap_word = slink_mm_data[18*i +: 18];
    end

    assign cap_sop = cap_word[17];
    assign cap_eop = cap_word[16];
    // The first word must carry sop, and no later word may carry it.
    assign sop_err = (word_cnt == '0) ? !cap_sop : cap_sop;

`ifdef SLINK_ARB_LEN_CHK_EN
    assign len_hit = (word_cnt == CNT_W'(MAX_PKT_WORDS - 1)) && !cap_eop;
`else
    assign len_hit = 1'b0;
`endif

    // A word truncated by the length check is closed with a forced eop.
    assign push_word = {grant, cap_sop, cap_eop | len_hit, cap_word[15:0]};
    assign push      = rdreq_d1 && (state == S_XFER);
    assign pop       = arb_mm_dval && arb_mm_rdy;

    always_ff @(posedge clk_rd) begin
        if (rst_rd) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= LAST_CH;
            word_cnt   <= '0;
            rdreq_d1   <= 1'b0;
            buf_cnt    <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
            arb_err    <= 1'b0;
        end else begin
            rdreq_d1 <= |mm_slink_rdreq;
            arb_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant    <= pick;
                        word_cnt <= '0;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (rdreq_d1) begin
                        arb_err <= sop_err | len_hit;
                        if (word_cnt != '1)
                            word_cnt <= word_cnt + 1'b1;
                        if (cap_eop) begin
                            state      <= S_IDLE;
                            last_grant <= grant;
                        end else if (len_hit) begin
                            state <= S_DROP;
                        end
                    end
                end
`ifdef SLINK_ARB_LEN_CHK_EN
                S_DROP: begin
                    if (rdreq_d1 && cap_eop) begin
                        state      <= S_IDLE;
                        last_grant <= grant;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase

            // A push into a full buffer cannot happen because of the read rule.
            case ({push, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0)
                        buf0 <= push_word;
                    else
                        buf1 <= push_word;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= push_word;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= push_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign arb_mm_dval = (buf_cnt != 2'd0);
    assign arb_mm_data = buf0[17:0];
    assign arb_mm_chn  = buf0[CH_W+17:18];
    assign arb_state   = state;

endmodule

// File: tb/tb_slink_rx_arb.sv
// Testbench for slink_rx_arb. Per-channel FIFO models feed the DUT. Each test
// pushes the words it expects into exp_q in the order they should appear. A
// monitor pops exp_q on every accepted output word and compares the two.

module tb_slink_rx_arb;

    localparam int CH_NUM = 4;
    localparam int CH_W   = 2;
`ifdef SLINK_ARB_LEN_CHK_EN
    localparam int MAXW = 8;
`else
    localparam int MAXW = 1024;
`endif
    localparam int EW = CH_W + 18;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [CH_NUM-1:0]    empty;
    logic [18*CH_NUM-1:0] din;
    logic [CH_NUM-1:0]    rdreq;
    logic                 rdy;
    logic                 dval;
    logic [17:0]          dout;
    logic [CH_W-1:0]      chn;
    logic                 err;
    logic [1:0]           st;

    logic [17:0]   fifo_q [CH_NUM][$];
    logic [EW-1:0] exp_q[$];
    int            acc_cyc[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            err_cnt = 0;
    int            rdreq_cnt [CH_NUM];

    slink_rx_arb #(.CH_NUM(CH_NUM), .CH_W(CH_W), .MAX_PKT_WORDS(MAXW)) dut (
        .clk_rd         (clk),
        .rst_rd         (rst),
        .slink_mm_empty (empty),
        .slink_mm_data  (din),
        .mm_slink_rdreq (rdreq),
        .arb_mm_rdy     (rdy),
        .arb_mm_dval    (dval),
        .arb_mm_data    (dout),
        .arb_mm_chn     (chn),
        .arb_err        (err),
        .arb_state      (st)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- FIFO models ----------------
    // rdreq is sampled mid-cycle. Read data appears just after the next edge,
    // and empty is refreshed a little later so that pushes made at the same
    // time are seen.
    initial begin : fifo_model
        logic [CH_NUM-1:0] rq_s;
        empty = '1;
        din   = '0;
        for (int i = 0; i < CH_NUM; i++) rdreq_cnt[i] = 0;
        forever begin
            @(negedge clk);
            rq_s = rdreq;
            @(posedge clk);
            #1;
            for (int i = 0; i < CH_NUM; i++) begin
                if (rq_s[i]) begin
                    checks++;
                    if (fifo_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL read_on_empty ch=%0d got rdreq=1 expected rdreq=0", i);
                    end else begin
                        din[18*i +: 18] = fifo_q[i].pop_front();
                    end
                end
            end
            #1;
            for (int i = 0; i < CH_NUM; i++) empty[i] = (fifo_q[i].size() == 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err) err_cnt++;
                for (int i = 0; i < CH_NUM; i++) if (rdreq[i]) rdreq_cnt[i]++;
                if (dval && rdy) begin
                    acc_cyc.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra got chn=%0d data=%h expected no word", chn, dout);
                    end else begin
                        e = exp_q.pop_front();
                        if ({chn, dout} !== e) begin
                            errors++;
                            $display("FAIL sb_word got chn=%0d data=%h expected chn=%0d data=%h",
                                     chn, dout, e[EW-1:18], e[17:0]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic s, input logic e, input int p);
        return {s, e, 16'(p)};
    endfunction

    task automatic fifo_pkt(input int ch, input int n, input int tag);
        for (int i = 0; i < n; i++)
            fifo_q[ch].push_back(mk(i == 0, i == n - 1, tag + i));
    endtask

    task automatic exp_pkt(input int ch, input int n, input int tag);
        for (int i = 0; i < n; i++)
            exp_q.push_back({CH_W'(ch), mk(i == 0, i == n - 1, tag + i)});
    endtask

    task automatic send_pkt(input int ch, input int n, input int tag);
        fifo_pkt(ch, n, tag);
        exp_pkt(ch, n, tag);
    endtask

    task automatic drain(input string name, input int limit);
        int t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            tick(1);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d words left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(3);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_dval"}, int'(dval), 0);
        chk({name, "_data"}, int'(dout), 0);
        chk({name, "_chn"}, int'(chn), 0);
        chk({name, "_err"}, int'(err), 0);
        chk({name, "_rdreq"}, int'(rdreq), 0);
        chk({name, "_state"}, int'(st), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog got time limit expected end of tests");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int c0, e0, r0, t;
        rdy = 1'b1;
        rst = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;

        // T1: single 4-word packet on ch0, latency and 2-cycle word spacing.
        acc_cyc.delete();
        e0 = err_cnt;
        c0 = cyc;
        send_pkt(0, 4, 'h1000);
        drain("t1", 100);
        chk("t1_words", acc_cyc.size(), 4);
        for (int k = 0; k < 4 && k < acc_cyc.size(); k++)
            chk($sformatf("t1_dval_cycle%0d", k), acc_cyc[k], c0 + 3 + 2 * k);
        chk("t1_err", err_cnt - e0, 0);

        // T2: round robin over ch0..ch2, ch0's second packet comes last.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        fifo_pkt(0, 2, 'h2000);
        fifo_pkt(0, 2, 'h2010);
        fifo_pkt(1, 2, 'h2100);
        fifo_pkt(2, 2, 'h2200);
        exp_pkt(0, 2, 'h2000);
        exp_pkt(1, 2, 'h2100);
        exp_pkt(2, 2, 'h2200);
        exp_pkt(0, 2, 'h2010);
        drain("t2", 200);

        // T3: downstream stall mid-packet.
        acc_cyc.delete();
        send_pkt(1, 6, 'h3100);
        t = 0;
        while (acc_cyc.size() < 2 && t < 50) begin
            tick(1);
            t++;
        end
        chk("t3_two_words_before_stall", int'(acc_cyc.size() >= 2), 1);
        rdy = 1'b0;
        r0 = rdreq_cnt[1];
        tick(10);
        chk("t3_stall_rdreq_le2", int'((rdreq_cnt[1] - r0) <= 2), 1);
        chk("t3_stall_dval", int'(dval), 1);
        chk("t3_stall_chn", int'(chn), 1);
        rdy = 1'b1;
        drain("t3", 100);

        // T4: granted channel runs empty mid-packet while ch1 waits.
        fifo_q[2].push_back(mk(1'b1, 1'b0, 'h4200));
        fifo_q[2].push_back(mk(1'b0, 1'b0, 'h4201));
        exp_pkt(2, 4, 'h4200);
        exp_pkt(1, 2, 'h4100);
        tick(8);
        fifo_pkt(1, 2, 'h4100);
        r0 = rdreq_cnt[1];
        tick(20);
        chk("t4_ch1_not_served", rdreq_cnt[1] - r0, 0);
        chk("t4_state_xfer", int'(st), 1);
        fifo_q[2].push_back(mk(1'b0, 1'b0, 'h4202));
        fifo_q[2].push_back(mk(1'b0, 1'b1, 'h4203));
        drain("t4", 200);

        // T5: sop inside a packet, then a packet whose first word lacks sop.
        e0 = err_cnt;
        fifo_q[3].push_back(mk(1'b1, 1'b0, 'h5300));
        fifo_q[3].push_back(mk(1'b0, 1'b0, 'h5301));
        fifo_q[3].push_back(mk(1'b1, 1'b0, 'h5302));
        fifo_q[3].push_back(mk(1'b0, 1'b1, 'h5303));
        exp_q.push_back({2'd3, mk(1'b1, 1'b0, 'h5300)});
        exp_q.push_back({2'd3, mk(1'b0, 1'b0, 'h5301)});
        exp_q.push_back({2'd3, mk(1'b1, 1'b0, 'h5302)});
        exp_q.push_back({2'd3, mk(1'b0, 1'b1, 'h5303)});
        drain("t5a", 100);
        chk("t5_mid_sop_err", err_cnt - e0, 1);
        e0 = err_cnt;
        fifo_q[0].push_back(mk(1'b0, 1'b0, 'h5000));
        fifo_q[0].push_back(mk(1'b0, 1'b1, 'h5001));
        exp_q.push_back({2'd0, mk(1'b0, 1'b0, 'h5000)});
        exp_q.push_back({2'd0, mk(1'b0, 1'b1, 'h5001)});
        drain("t5b", 100);
        chk("t5_no_sop_err", err_cnt - e0, 1);

`ifdef SLINK_ARB_LEN_CHK_EN
        // T5c: 12-word packet against an 8-word limit, then a normal packet.
        e0 = err_cnt;
        fifo_pkt(1, 12, 'h5100);
        fifo_pkt(1, 2, 'h5180);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({2'd1, mk(i == 0, i == 7, 'h5100 + i)});
        exp_pkt(1, 2, 'h5180);
        drain("t5c", 200);
        chk("t5c_len_err", err_cnt - e0, 1);
        chk("t5c_ch1_consumed", fifo_q[1].size(), 0);
`endif

        // T6: reset during XFER with one word buffered.
        rdy = 1'b0;
        fifo_pkt(1, 4, 'h6100);
        t = 0;
        while (!dval && t < 20) begin
            tick(1);
            t++;
        end
        chk("t6_dval_before_reset", int'(dval), 1);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("t6_after_reset");
        tick(2);
        for (int i = 0; i < CH_NUM; i++) fifo_q[i].delete();
        tick(2);
        rst = 1'b0;
        rdy = 1'b1;
        fifo_pkt(2, 2, 'h6200);
        fifo_pkt(0, 2, 'h6000);
        exp_pkt(0, 2, 'h6000);
        exp_pkt(2, 2, 'h6200);
        drain("t6", 100);

        chk("final_exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slink_rx_arb.md
# slink_rx_arb

Packet-granular round-robin scheduler that drains CH_NUM slink receive packet FIFOs and merges them onto one valid/ready stream toward the MM side. It sits between the per-link 8-to-16-bit receive FIFO stages and the single MM consumer. It issues per-channel read requests, never interleaves packets, and polices packet framing and length.

## Interface
- CH_NUM, 4, number of slink receive channels (2..8)
- CH_W, 2, width of channel index; CH_NUM <= 2**CH_W
- MAX_PKT_WORDS, 1024, longest legal packet in 16-bit words
- clk_rd  in  1  single clock for the whole block
- rst_rd  in  1  reset, synchronous, active-high
- slink_mm_empty  in  CH_NUM  per-channel FIFO empty
- slink_mm_data  in  18*CH_NUM  per-channel FIFO read data; channel i at [18i+17:18i]; bit17 sop, bit16 eop, [15:0] payload
- mm_slink_rdreq  out  CH_NUM  per-channel read request; data valid one cycle later
- arb_mm_rdy  in  1  downstream accepts word
- arb_mm_dval  out  1  output word valid, held until accepted
- arb_mm_data  out  18  output word, same bit map as input
- arb_mm_chn  out  CH_W  source channel of current output word
- arb_err  out  1  one-cycle framing/length error pulse

## Operation
- States: IDLE, XFER, DROP.
- IDLE:
  - Pick the first channel with empty=0, searching from last_grant+1 with wrap.
  - Register it as grant, clear word_cnt, go to XFER.
  - If all channels are empty, stay in IDLE.
- XFER:
  - Assert mm_slink_rdreq[grant] when all hold: empty[grant]=0, no read in flight (rdreq_d1=0), and buf_cnt+rdreq_d1<2.
  - Only one read is outstanding at a time.
  - The word is captured in the cycle after rdreq (rdreq_d1=1) into a 2-entry output buffer, together with the grant index.
- Captured word has eop=1: go to IDLE, last_grant<=grant.
- Captured sop=1 with word_cnt!=0: pulse arb_err. The word is forwarded unchanged.
- Captured first word with sop=0: pulse arb_err. The word is forwarded.
- word_cnt increments per captured word (saturating, 11 bits min).
- Empty mid-packet: stall in XFER indefinitely. No rdreq is issued and nothing is lost.
- Output buffer:
  - arb_mm_dval = buf_cnt!=0.
  - Pop when arb_mm_dval & arb_mm_rdy.
  - Simultaneous push and pop keeps buf_cnt.
  - Push into a full buffer cannot occur, because the rdreq rule prevents it.
- No packet interleaving: arb_mm_chn is constant from sop to eop.

## Timing
- Reset values: mm_slink_rdreq=0, arb_mm_dval=0, arb_mm_data=0, arb_mm_chn=0, arb_err=0, state=IDLE, last_grant=CH_NUM-1 (first pick is channel 0), buf_cnt=0.
- Reset mid-packet: everything returns to reset values next cycle. Partial packets in the buffer are discarded.
- Latency, from a channel going non-empty in IDLE at cycle n:
  - grant at n+1 (XFER)
  - rdreq at n+1
  - capture at n+2
  - arb_mm_dval at n+3
- Peak throughput is 1 word per 2 cycles, which matches the byte-rate receive path.
- Packet gap: capture of eop at cycle m, IDLE at m+1, next rdreq at m+2 at the earliest.
- mm_slink_rdreq is combinational from registered state and slink_mm_empty.

## Configuration
- SLINK_ARB_LEN_CHK_EN defined:
  - When word_cnt reaches MAX_PKT_WORDS without eop, that word is forwarded with bit16 forced to 1.
  - arb_err pulses and the block enters DROP.
  - DROP reads grant using the same rdreq rule (ignoring buffer space) and discards words until an eop word is captured, then goes to IDLE.
- Not defined:
  - No length check and no DROP state.
  - arb_err reports sop violations only.

## Test plan
- Channel 0 only, 4-word packet (sop on w0, eop on w3), rdy=1 -> 4 words out in order, chn=0, dval spaced every 2 cycles, first dval 3 cycles after empty falls.
- Channels 0,1,2 each hold one 2-word packet, rdy=1 -> output order ch0, ch1, ch2, then ch0's next packet; no interleave.
- Stall: rdy=0 for 10 cycles mid-packet -> at most 2 words buffered, no rdreq while full, no loss/duplication after rdy=1.
- Empty mid-packet on granted channel for 20 cycles while ch1 has data -> grant held, ch1 not served until eop of current packet.
- Sop inside packet at word 2 -> arb_err one pulse, word forwarded; with SLINK_ARB_LEN_CHK_EN and MAX_PKT_WORDS=8, 12-word packet -> 8 words out with eop on word 8, arb_err pulse, words 9-12 dropped, next packet normal.
- Assert rst_rd during XFER with 1 word buffered -> next cycle all outputs 0, next packet starts from channel 0.
